// File: rtl/mem_wb_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_reg_if
//   Bundle of every signal crossing the MEM->WB pipeline register boundary:
//   the upstream beat (in_*), the downstream beat (out_*), the handshakes
//   and the pipeline flush.
//
//   modport slave  : the pipeline register itself (takes in_*, flush,
//                    out_ready; drives in_ready and all out_* / WB results)
//   modport master : the surrounding pipeline (drives the MEM beat, flush and
//                    WB ready; observes the register outputs)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_wb_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;

  logic                  in_valid;
  logic                  in_ready;
  logic                  RegWrite_in;
  logic                  MemtoReg_in;
  logic [DATA_W-1:0]     Alu_result_in;
  logic [DATA_W-1:0]     Read_data_in;
  logic [REG_ADDR_W-1:0] Dest_in;

  logic                  out_valid;
  logic                  out_ready;
  logic                  RegWrite_out;
  logic                  MemtoReg_out;
  logic [DATA_W-1:0]     Alu_result_out;
  logic [DATA_W-1:0]     Read_data_out;
  logic [REG_ADDR_W-1:0] Dest_out;
  logic [DATA_W-1:0]     Wb_data_out;
  logic                  Fwd_valid;

  modport master (
    output flush,
    output in_valid, RegWrite_in, MemtoReg_in, Alu_result_in, Read_data_in, Dest_in,
    input  in_ready,
    output out_ready,
    input  out_valid, RegWrite_out, MemtoReg_out, Alu_result_out, Read_data_out,
    input  Dest_out, Wb_data_out, Fwd_valid
  );

  modport slave (
    input  flush,
    input  in_valid, RegWrite_in, MemtoReg_in, Alu_result_in, Read_data_in, Dest_in,
    output in_ready,
    input  out_ready,
    output out_valid, RegWrite_out, MemtoReg_out, Alu_result_out, Read_data_out,
    output Dest_out, Wb_data_out, Fwd_valid
  );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe_reg
//   MEM->WB pipeline register with valid/ready handshake, flush and an
//   optional 2-entry skid buffer. Carries RegWrite/MemtoReg, ALU result,
//   memory read data and destination index into write-back, and produces the
//   final write-back value plus a forwarding-valid flag.
//
// Parameters
//   DATA_W      width of ALU result / read data / write-back data
//   REG_ADDR_W  width of destination register index
//   SKID        1: main + skid entry, registered in_ready, full throughput
//               0: single entry, in_ready = !out_valid | out_ready
//
// Ports
//   CLK    clock, rising edge
//   RST_N  asynchronous reset, active low (clears valid bits and payload)
//   bus    mem_wb_pipe_reg_if.slave: flush, in_* beat + in_ready,
//          out_* beat + out_ready, Wb_data_out, Fwd_valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_wb_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID       = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  mem_wb_pipe_reg_if.slave    bus
);

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
    logic [REG_ADDR_W-1:0] dest;
  } beat_t;

  beat_t in_beat;
  beat_t m_beat_reg, m_beat_next;
  logic  m_valid_reg, m_valid_next;
  logic  accept, consume;

  assign in_beat.regwrite   = bus.RegWrite_in;
  assign in_beat.memtoreg   = bus.MemtoReg_in;
  assign in_beat.alu_result = bus.Alu_result_in;
  assign in_beat.read_data  = bus.Read_data_in;
  assign in_beat.dest       = bus.Dest_in;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = m_valid_reg & bus.out_ready;

  // Main entry: always the one presented on the outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_reg <= 1'b0;
      m_beat_reg  <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      m_beat_reg  <= m_beat_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      beat_t s_beat_reg, s_beat_next;
      logic  s_valid_reg, s_valid_next;

      // Registered ready: we only refuse input while the skid slot is full,
      // so a beat arriving in the same cycle that WB stalls always has a home.
      assign bus.in_ready = !s_valid_reg;

      always_comb begin
        m_valid_next = m_valid_reg;
        m_beat_next  = m_beat_reg;
        s_valid_next = s_valid_reg;
        s_beat_next  = s_beat_reg;
        if (bus.flush) begin
          // Flush beats everything; payload is left stale on purpose.
          m_valid_next = 1'b0;
          s_valid_next = 1'b0;
        end else if (s_valid_reg) begin
          // Both entries full (in_ready is low): only a shift can happen.
          if (bus.out_ready) begin
            m_beat_next  = s_beat_reg;
            s_valid_next = 1'b0;
          end
        end else if (accept) begin
          if (!m_valid_reg || bus.out_ready) begin
            m_valid_next = 1'b1;
            m_beat_next  = in_beat;
          end else begin
            s_valid_next = 1'b1;
            s_beat_next  = in_beat;
          end
        end else if (consume) begin
          m_valid_next = 1'b0;
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s_valid_reg <= 1'b0;
          s_beat_reg  <= '0;
        end else begin
          s_valid_reg <= s_valid_next;
          s_beat_reg  <= s_beat_next;
        end
      end
    end else begin : g_single
      // Combinational ready: a beat leaving this cycle frees the entry for
      // the incoming one on the same edge.
      assign bus.in_ready = !m_valid_reg | bus.out_ready;

      always_comb begin
        m_valid_next = m_valid_reg;
        m_beat_next  = m_beat_reg;
        if (bus.flush) begin
          m_valid_next = 1'b0;
        end else if (accept) begin
          m_valid_next = 1'b1;
          m_beat_next  = in_beat;
        end else if (consume) begin
          m_valid_next = 1'b0;
        end
      end
    end
  endgenerate

  // Outputs are purely combinational from the main entry. Control bits that
  // cause architectural side effects are gated by valid so a bubble or a
  // flushed stale entry can never write the register file or forward.
  assign bus.out_valid      = m_valid_reg;
  assign bus.RegWrite_out   = m_valid_reg & m_beat_reg.regwrite;
  assign bus.MemtoReg_out   = m_beat_reg.memtoreg;
  assign bus.Alu_result_out = m_beat_reg.alu_result;
  assign bus.Read_data_out  = m_beat_reg.read_data;
  assign bus.Dest_out       = m_beat_reg.dest;
  assign bus.Wb_data_out    = m_beat_reg.memtoreg ? m_beat_reg.read_data
                                                  : m_beat_reg.alu_result;
  // r0 is hard-wired zero, so writes to it are never worth forwarding.
  assign bus.Fwd_valid      = m_valid_reg & m_beat_reg.regwrite
                              & (m_beat_reg.dest != '0);

endmodule
